// File: rtl/sw_segment_dispatch_pkg.sv
// Shared types and helpers for the Smith-Waterman segment dispatcher.
package sw_segment_dispatch_pkg;

    // Default PE result widths.
    localparam int unsigned DefMaxW = 7;
    localparam int unsigned DefLocW = 13;

    // Dispatcher control states.
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRun,
        StDone
    } state_e;

    // LSB of window k inside a packed job; lane 0 is the most-significant window.
    function automatic int unsigned win_lsb(input int unsigned k,
                                            input int unsigned total_w,
                                            input int unsigned pe_w,
                                            input int unsigned stride);
        return total_w - k * stride - pe_w;
    endfunction

endpackage

// File: rtl/sw_lane_collect.sv
// Per-lane result collector: first done in RUN latches max/loc, later dones are ignored.
module sw_lane_collect
    import sw_segment_dispatch_pkg::*;
#(
    parameter int unsigned MAX_W = DefMaxW,
    parameter int unsigned LOC_W = DefLocW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_done,
    input  logic [MAX_W-1:0] i_max,
    input  logic [LOC_W-1:0] i_loc,
    output logic             o_done,
    output logic [MAX_W-1:0] o_max,
    output logic [LOC_W-1:0] o_loc
);

    logic             r_done;
    logic [MAX_W-1:0] r_max;
    logic [LOC_W-1:0] r_loc;

    // Clear on issue; capture the lane result once while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_max  <= '0;
            r_loc  <= '0;
        end else if (i_clear) begin
            r_done <= 1'b0;
            r_max  <= '0;
            r_loc  <= '0;
        end else if (i_enable && i_done && !r_done) begin
            r_done <= 1'b1;
            r_max  <= i_max;
            r_loc  <= i_loc;
        end
    end

    assign o_done = r_done;
    assign o_max  = r_max;
    assign o_loc  = r_loc;

endmodule

// File: rtl/sw_segment_dispatch.sv
// Job buffer, window slicer and result gatherer in front of an NUM_PE-lane SW PE array.
module sw_segment_dispatch
    import sw_segment_dispatch_pkg::*;
#(
    parameter int unsigned NUM_PE      = 4,
    parameter int unsigned PE_WIDTH    = 72,
    parameter int unsigned PE_STRIDE   = 60,
    parameter int unsigned TOTAL_WIDTH = 252,
    parameter int unsigned MAX_W       = DefMaxW,
    parameter int unsigned LOC_W       = DefLocW,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TOTAL_WIDTH-1:0]     in_ref,
    input  logic [TOTAL_WIDTH-1:0]     in_read,
    output logic                       pe_start,
    output logic [NUM_PE*PE_WIDTH-1:0] pe_ref,
    output logic [NUM_PE*PE_WIDTH-1:0] pe_read,
    input  logic [NUM_PE-1:0]          pe_done,
    input  logic [NUM_PE*MAX_W-1:0]    pe_max,
    input  logic [NUM_PE*LOC_W-1:0]    pe_loc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_PE*MAX_W-1:0]    out_max,
    output logic [NUM_PE*LOC_W-1:0]    out_loc,
    output logic [NUM_PE-1:0]          out_lane_ok,
    output logic                       out_timeout,
    output logic                       busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    // Windows must tile the job exactly.
    if (TOTAL_WIDTH != PE_WIDTH + (NUM_PE - 1) * PE_STRIDE) begin : g_bad_width
        $error("TOTAL_WIDTH must equal PE_WIDTH + (NUM_PE-1)*PE_STRIDE");
    end

    state_e                     r_state;
    state_e                     w_state_d;
    logic                       r_pend_valid;
    logic [TOTAL_WIDTH-1:0]     r_pend_ref;
    logic [TOTAL_WIDTH-1:0]     r_pend_read;
    logic [NUM_PE*PE_WIDTH-1:0] r_pe_ref;
    logic [NUM_PE*PE_WIDTH-1:0] r_pe_read;
    logic [NUM_PE*PE_WIDTH-1:0] w_ref_win;
    logic [NUM_PE*PE_WIDTH-1:0] w_read_win;
    logic [CntW-1:0]            r_cnt;
    logic                       r_timeout;
    logic [NUM_PE-1:0]          w_lane_done;
    logic                       w_accept;
    logic                       w_all_done;
    logic                       w_cnt_exp;

    assign w_accept = in_valid && !r_pend_valid;
    // Mask including lanes finishing this cycle, so the last done moves to DONE immediately.
    assign w_all_done = &(w_lane_done | pe_done);
    assign w_cnt_exp  = (r_cnt == CntW'(TIMEOUT_CYC - 1));

    // Slice the pending job into overlapping lane windows.
    for (genvar k = 0; k < NUM_PE; k++) begin : g_win
        localparam int unsigned Lsb = win_lsb(k, TOTAL_WIDTH, PE_WIDTH, PE_STRIDE);
        assign w_ref_win[k*PE_WIDTH +: PE_WIDTH]  = r_pend_ref[Lsb +: PE_WIDTH];
        assign w_read_win[k*PE_WIDTH +: PE_WIDTH] = r_pend_read[Lsb +: PE_WIDTH];
    end

    // One-deep pending job slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_valid <= 1'b0;
            r_pend_ref   <= '0;
            r_pend_read  <= '0;
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_ref   <= in_ref;
            r_pend_read  <= in_read;
        end else if (r_state == StIssue) begin
            r_pend_valid <= 1'b0;
        end
    end

    // PE windows load on entry to ISSUE so they are valid alongside pe_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pe_ref  <= '0;
            r_pe_read <= '0;
        end else if (w_state_d == StIssue) begin
            r_pe_ref  <= w_ref_win;
            r_pe_read <= w_read_win;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (r_pend_valid) w_state_d = StIssue;
            StIssue: w_state_d = StRun;
            StRun:   if (w_all_done || w_cnt_exp) w_state_d = StDone;
            StDone:  if (out_ready) w_state_d = r_pend_valid ? StIssue : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // RUN cycle counter and timeout flag; completion wins over a coincident timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == StIssue) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == StRun) begin
            r_cnt <= r_cnt + CntW'(1);
            if (w_cnt_exp && !w_all_done) begin
                r_timeout <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
        sw_lane_collect #(
            .MAX_W (MAX_W),
            .LOC_W (LOC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (r_state == StIssue),
            .i_enable (r_state == StRun),
            .i_done   (pe_done[k]),
            .i_max    (pe_max[k*MAX_W +: MAX_W]),
            .i_loc    (pe_loc[k*LOC_W +: LOC_W]),
            .o_done   (w_lane_done[k]),
            .o_max    (out_max[k*MAX_W +: MAX_W]),
            .o_loc    (out_loc[k*LOC_W +: LOC_W])
        );
    end

    assign in_ready    = !r_pend_valid;
    assign pe_start    = (r_state == StIssue);
    assign pe_ref      = r_pe_ref;
    assign pe_read     = r_pe_read;
    assign out_valid   = (r_state == StDone);
    assign out_lane_ok = w_lane_done;
    assign out_timeout = r_timeout;
    assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_sw_segment_dispatch.sv
// Scoreboard bench for sw_segment_dispatch (TIMEOUT_CYC shortened to 20).
module tb_sw_segment_dispatch;

    localparam int unsigned NPE = 4;
    localparam int unsigned PW  = 72;
    localparam int unsigned PS  = 60;
    localparam int unsigned TW  = 252;
    localparam int unsigned MW  = 7;
    localparam int unsigned LW  = 13;
    localparam int unsigned TO  = 20;

    typedef struct {
        logic [TW-1:0] r;
        logic [TW-1:0] rd;
    } job_t;

    typedef struct {
        logic [NPE*MW-1:0] mx;
        logic [NPE*LW-1:0] lc;
        logic [NPE-1:0]    ok;
        logic              to;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid;
    logic              in_ready;
    logic [TW-1:0]     in_ref;
    logic [TW-1:0]     in_read;
    logic              pe_start;
    logic [NPE*PW-1:0] pe_ref;
    logic [NPE*PW-1:0] pe_read;
    logic [NPE-1:0]    pe_done;
    logic [NPE*MW-1:0] pe_max;
    logic [NPE*LW-1:0] pe_loc;
    logic              out_valid;
    logic              out_ready;
    logic [NPE*MW-1:0] out_max;
    logic [NPE*LW-1:0] out_loc;
    logic [NPE-1:0]    out_lane_ok;
    logic              out_timeout;
    logic              busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    job_t src_q[$];
    job_t exp_job_q[$];
    res_t res_q[$];

    sw_segment_dispatch #(
        .NUM_PE      (NPE),
        .PE_WIDTH    (PW),
        .PE_STRIDE   (PS),
        .TOTAL_WIDTH (TW),
        .MAX_W       (MW),
        .LOC_W       (LW),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ref      (in_ref),
        .in_read     (in_read),
        .pe_start    (pe_start),
        .pe_ref      (pe_ref),
        .pe_read     (pe_read),
        .pe_done     (pe_done),
        .pe_max      (pe_max),
        .pe_loc      (pe_loc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_loc     (out_loc),
        .out_lane_ok (out_lane_ok),
        .out_timeout (out_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic job_t rand_job();
        job_t j;
        for (int i = 0; i < TW / 4; i++) begin
            j.r[i*4 +: 4]  = 4'($urandom);
            j.rd[i*4 +: 4] = 4'($urandom);
        end
        return j;
    endfunction

    // Job source: offers queued jobs; every accept pushes the expected windows.
    initial begin
        bit   drop;
        job_t j;
        forever begin
            @(negedge clk);
            drop = 1'b0;
            if (rst && in_valid && in_ready) begin
                j.r  = in_ref;
                j.rd = in_read;
                exp_job_q.push_back(j);
                acc_cyc = cyc;
                drop = 1'b1;
            end
            @(posedge clk);
            #2;
            if (drop) in_valid = 1'b0;
            if (!in_valid && src_q.size() > 0) begin
                j = src_q.pop_front();
                in_ref   = j.r;
                in_read  = j.rd;
                in_valid = 1'b1;
            end
        end
    end

    // Result monitor: pops expected result on first valid cycle, re-checks while stalled.
    initial begin
        bit   seen;
        res_t cur;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    check_val("result_expected", 512'(res_q.size() != 0), 512'(1));
                    if (res_q.size() != 0) cur = res_q.pop_front();
                    seen = 1'b1;
                end
                check_val("out_max", 512'(out_max), 512'(cur.mx));
                check_val("out_loc", 512'(out_loc), 512'(cur.lc));
                check_val("out_lane_ok", 512'(out_lane_ok), 512'(cur.ok));
                check_val("out_timeout", 512'(out_timeout), 512'(cur.to));
                if (out_ready) seen = 1'b0;
            end
        end
    end

    // Waits for pe_start, then checks windows of the oldest accepted job.
    task automatic wait_start(input int exp_lat);
        job_t          j;
        logic [NPE*PW-1:0] er;
        logic [NPE*PW-1:0] ed;
        int            n;
        n = 0;
        while (pe_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_val("start_seen", 512'(pe_start), 512'(1));
        if (exp_lat >= 0) check_val("start_latency", 512'(n), 512'(exp_lat));
        check_val("job_expected", 512'(exp_job_q.size() != 0), 512'(1));
        if (exp_job_q.size() != 0) begin
            j = exp_job_q.pop_front();
            for (int k = 0; k < NPE; k++) begin
                er[k*PW +: PW] = j.r[TW-1-k*PS -: PW];
                ed[k*PW +: PW] = j.rd[TW-1-k*PS -: PW];
            end
            check_val("pe_ref", 512'(pe_ref), 512'(er));
            check_val("pe_read", 512'(pe_read), 512'(ed));
        end
    endtask

    // Called in the pe_start cycle. dly lane k = RUN cycle of its done (0 = never).
    task automatic run_pe(input logic [8*NPE-1:0] dly, input logic [NPE*MW-1:0] mx,
                          input logic [NPE*LW-1:0] lc, input bit level);
        res_t        e;
        int unsigned t_end;
        int unsigned d;
        bit          all_done;
        all_done = 1'b1;
        t_end    = 0;
        for (int k = 0; k < NPE; k++) begin
            d = dly[k*8 +: 8];
            if (d == 0 || d > TO) all_done = 1'b0;
            else if (d > t_end) t_end = d;
        end
        if (!all_done) t_end = TO;
        for (int k = 0; k < NPE; k++) begin
            d = dly[k*8 +: 8];
            e.ok[k] = (d != 0 && d <= t_end);
            e.mx[k*MW +: MW] = e.ok[k] ? mx[k*MW +: MW] : '0;
            e.lc[k*LW +: LW] = e.ok[k] ? lc[k*LW +: LW] : '0;
        end
        e.to = !all_done;
        res_q.push_back(e);
        // Dones during ISSUE must be ignored.
        pe_done = '1;
        pe_max  = 28'($urandom);
        pe_loc  = 52'({$urandom, $urandom});
        for (int t = 1; t <= int'(t_end); t++) begin
            tick();
            if (t == 1) check_val("start_one_cycle", 512'(pe_start), 512'(0));
            if (t == int'(t_end)) check_val("valid_before_last", 512'(out_valid), 512'(0));
            for (int k = 0; k < NPE; k++) begin
                d = dly[k*8 +: 8];
                pe_done[k] = level ? (d != 0 && t >= int'(d)) : (t == int'(d));
                pe_max[k*MW +: MW] = (t == int'(d)) ? mx[k*MW +: MW] : 7'($urandom);
                pe_loc[k*LW +: LW] = (t == int'(d)) ? lc[k*LW +: LW] : 13'($urandom);
            end
        end
        tick();
        pe_done = '0;
        check_val("result_latency", 512'(out_valid), 512'(1));
    endtask

    initial begin
        job_t j;
        in_valid  = 1'b0;
        in_ref    = '0;
        in_read   = '0;
        pe_done   = '0;
        pe_max    = '0;
        pe_loc    = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_val("rst_in_ready", 512'(in_ready), 512'(1));
        check_val("rst_out_valid", 512'(out_valid), 512'(0));
        check_val("rst_pe_start", 512'(pe_start), 512'(0));
        check_val("rst_busy", 512'(busy), 512'(0));
        check_val("rst_lane_ok", 512'(out_lane_ok), 512'(0));
        check_val("rst_pe_ref", 512'(pe_ref), 512'(0));
        check_val("rst_out_max", 512'(out_max), 512'(0));
        rst = 1'b1;
        repeat (2) tick();

        // Window slicing: byte index per nibble, all lanes done at +5.
        j = rand_job();
        for (int i = 0; i < TW / 4; i++) j.r[i*4 +: 4] = 4'(i / 2);
        src_q.push_back(j);
        wait_start(-1);
        check_val("accept_to_start", 512'(cyc - acc_cyc), 512'(2));
        run_pe({4{8'd5}}, 28'($urandom), 52'({$urandom, $urandom}), 1'b0);
        tick();
        check_val("valid_drop", 512'(out_valid), 512'(0));

        // Staggered level dones; later reassertions carry junk and must be ignored.
        src_q.push_back(rand_job());
        wait_start(-1);
        run_pe({8'd9, 8'd2, 8'd7, 8'd3}, {7'd78, 7'd56, 7'd34, 7'd12},
               {13'd4000, 13'd3000, 13'd2000, 13'd1000}, 1'b1);
        tick();

        // Timeout with lane 2 silent.
        src_q.push_back(rand_job());
        wait_start(-1);
        run_pe({8'd6, 8'd0, 8'd4, 8'd3}, 28'($urandom), 52'({$urandom, $urandom}), 1'b0);
        tick();

        // Final done coincides with the timeout cycle.
        src_q.push_back(rand_job());
        wait_start(-1);
        run_pe({8'd5, 8'd5, 8'd5, 8'd20}, 28'($urandom), 52'({$urandom, $urandom}), 1'b1);
        tick();

        // Back-to-back with backpressure.
        out_ready = 1'b0;
        src_q.push_back(rand_job());
        src_q.push_back(rand_job());
        src_q.push_back(rand_job());
        wait_start(-1);
        run_pe({4{8'd2}}, 28'($urandom), 52'({$urandom, $urandom}), 1'b0);
        pe_done = '1;
        pe_max  = 28'($urandom);
        for (int i = 0; i < 10; i++) begin
            check_val("job3_offered", 512'(in_valid), 512'(1));
            check_val("job3_stall", 512'(in_ready), 512'(0));
            check_val("result1_held", 512'(out_valid), 512'(1));
            tick();
        end
        pe_done   = '0;
        out_ready = 1'b1;
        tick();
        wait_start(0);
        run_pe({8'd1, 8'd4, 8'd3, 8'd2}, 28'($urandom), 52'({$urandom, $urandom}), 1'b0);
        wait_start(1);
        run_pe({8'd3, 8'd3, 8'd8, 8'd1}, 28'($urandom), 52'({$urandom, $urandom}), 1'b1);
        tick();

        // Reset mid-RUN with a second job pending.
        src_q.push_back(rand_job());
        src_q.push_back(rand_job());
        wait_start(-1);
        pe_done = '0;
        tick();
        pe_done = 4'b0011;
        tick();
        pe_done = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 512'(out_valid), 512'(0));
        check_val("mid_rst_pe_start", 512'(pe_start), 512'(0));
        check_val("mid_rst_busy", 512'(busy), 512'(0));
        check_val("mid_rst_in_ready", 512'(in_ready), 512'(1));
        check_val("mid_rst_lane_ok", 512'(out_lane_ok), 512'(0));
        exp_job_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("pending_discarded", 512'(busy), 512'(0));
        end
        src_q.push_back(rand_job());
        wait_start(-1);
        run_pe({8'd4, 8'd0, 8'd0, 8'd0}, 28'($urandom), 52'({$urandom, $urandom}), 1'b0);
        repeat (3) tick();

        check_val("results_drained", 512'(res_q.size()), 512'(0));
        check_val("jobs_drained", 512'(exp_job_q.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
